// File: rtl/handshake_slave_mc.sv
// Multi-channel 4-phase req/ack slave with round-robin grant,
// programmable ack delay and a show-ahead {chan,data} FIFO.
module handshake_slave_mc #(
  parameter int NCH     = 4,
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int ACK_DLY = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCH-1:0]           req,
  output logic [NCH-1:0]           ack,
  input  logic [NCH*DW-1:0]        data_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [$clog2(NCH)-1:0]   out_chan,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     proto_err,
  output logic                     busy
);

  localparam int CW  = $clog2(NCH);
  localparam int AW  = $clog2(DEPTH);
  localparam int CNW = AW + 1;
  localparam int EW  = CW + DW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CAPTURE,
    S_DELAY,
    S_ACK,
    S_WAIT_REL
  } state_t;

  state_t          state, nxt;
  logic [CW-1:0]   sel, last, rr_sel;
  logic            rr_hit;
  logic [3:0]      dly_cnt;
  logic            grant, push, pop, wr, full;
  logic [AW-1:0]   wptr, rptr;
  logic [EW-1:0]   mem [DEPTH];
  int              idx;

  assign full      = fifo_count == CNW'(DEPTH);
  assign out_valid = fifo_count != '0;
  assign pop       = out_valid && out_ready;
  assign wr        = push && !full;
  assign busy      = state != S_IDLE;
  assign {out_chan, out_data} = mem[rptr];

  // Scan starts one past the last served channel
  always_comb begin
    rr_hit = 1'b0;
    rr_sel = last;
    idx    = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(last) + 1 + i) % NCH;
      if (!rr_hit && req[idx]) begin
        rr_hit = 1'b1;
        rr_sel = CW'(idx);
      end
    end
  end

  always_comb begin
    nxt   = state;
    grant = 1'b0;
    push  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (rr_hit && !full) begin
          grant = 1'b1;
          nxt   = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        push = 1'b1;
        nxt  = (ACK_DLY == 0) ? S_ACK : S_DELAY;
      end
      S_DELAY:    if (dly_cnt == 4'd1) nxt = S_ACK;
      S_ACK:      if (!req[sel]) nxt = S_WAIT_REL;
      S_WAIT_REL: nxt = S_IDLE;
      default:    nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack = '0;
    if (state == S_ACK) ack[sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      sel       <= '0;
      last      <= CW'(NCH - 1);
      dly_cnt   <= '0;
      proto_err <= 1'b0;
    end else begin
      state <= nxt;
      if (grant) sel <= rr_sel;
      if (state == S_WAIT_REL) last <= sel;
      if (state == S_CAPTURE) dly_cnt <= 4'(ACK_DLY);
      else if (state == S_DELAY) dly_cnt <= dly_cnt - 4'd1;
      if ((state == S_CAPTURE || state == S_DELAY) && !req[sel])
        proto_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      if (wr && !pop) fifo_count <= fifo_count + CNW'(1);
      else if (!wr && pop) fifo_count <= fifo_count - CNW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= {sel, data_in[sel*DW +: DW]};
  end

endmodule

// File: tb/tb_handshake_slave_mc.sv
// Random requesters/consumer against a timestamp-based
// transaction model of the handshake slave.
module tb_handshake_slave_mc;

  localparam int NCH   = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int D     = 2;
  localparam int CW    = $clog2(NCH);
  localparam int NCYC  = 3000;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCH-1:0]         req;
  logic [NCH-1:0]         ack;
  logic [NCH*DW-1:0]      data_in;
  logic                   out_valid;
  logic                   out_ready;
  logic [DW-1:0]          out_data;
  logic [CW-1:0]          out_chan;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   proto_err;
  logic                   busy;

  logic [DW-1:0] dat [NCH];
  int            rs  [NCH];

  int nvec = 0;
  int nerr = 0;

  handshake_slave_mc #(
    .NCH(NCH), .DW(DW), .DEPTH(DEPTH), .ACK_DLY(D)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack),
    .data_in(data_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .fifo_count(fifo_count),
    .proto_err(proto_err), .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    data_in = '0;
    for (int i = 0; i < NCH; i++) data_in[i*DW +: DW] = dat[i];
  end

  // model: handshake described by its grant and release edges
  logic [CW+DW-1:0] mq [$];
  int  n, g_edge, gch, rel, next_ok, m_last;
  bit  hs, m_err;
  int  e_ack;
  bit  e_busy;

  function automatic void model_reset();
    mq.delete();
    n = 0; g_edge = 0; gch = 0; rel = -10;
    next_ok = 0; m_last = NCH - 1;
    hs = 0; m_err = 0; e_ack = 0; e_busy = 0;
  endfunction

  function automatic void model_step();
    int  cnt;
    bit  pop, found;
    cnt = mq.size();
    pop = cnt > 0 && out_ready;
    if (hs) begin
      if (n == g_edge + 1) mq.push_back({CW'(gch), dat[gch]});
      if (n >= g_edge + 1 && n <= g_edge + 1 + D && !req[gch]) m_err = 1;
      if (n >= g_edge + 2 + D && !req[gch]) begin
        hs = 0; rel = n; m_last = gch; next_ok = n + 2;
      end
    end else if (n >= next_ok && cnt < DEPTH && |req) begin
      found = 0;
      for (int k = 1; k <= NCH; k++) begin
        if (!found && req[(m_last + k) % NCH]) begin
          found = 1; gch = (m_last + k) % NCH;
        end
      end
      hs = 1; g_edge = n;
    end
    if (pop) void'(mq.pop_front());
    e_ack  = (hs && n >= g_edge + 1 + D) ? (1 << gch) : 0;
    e_busy = hs || (n == rel);
    n++;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("ack", 32'(ack), 32'(e_ack));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("count", 32'(fifo_count), 32'(mq.size()));
    chk("perr", 32'(proto_err), 32'(m_err));
    if (mq.size() > 0) begin
      chk("data", 32'(out_data), 32'(mq[0][DW-1:0]));
      chk("chan", 32'(out_chan), 32'(mq[0][DW +: CW]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(int cyc);
    int  rate;
    bit  viol;
    viol = cyc >= 2200;
    rate = (cyc % 500 < 250) ? 30 : 8;
    case ((cyc / 250) % 3)
      0:       out_ready = 1'b0;
      1:       out_ready = $urandom_range(0, 99) < 40;
      default: out_ready = $urandom_range(0, 99) < 95;
    endcase
    for (int i = 0; i < NCH; i++) begin
      case (rs[i])
        0: if ($urandom_range(0, 99) < rate) begin
          dat[i] = DW'($urandom); req[i] = 1'b1; rs[i] = 1;
        end
        1: if (ack[i]) begin
          if ($urandom_range(0, 2) != 0) begin
            req[i] = 1'b0; rs[i] = 2;
          end
        end else if (viol && $urandom_range(0, 99) < 3) begin
          req[i] = 1'b0; rs[i] = 0;
        end
        default: if (!ack[i]) rs[i] = 0;
      endcase
    end
  endtask

  initial begin
    bit did_rst;
    did_rst = 0;
    rst = 1'b1; req = '0; out_ready = 1'b0;
    for (int i = 0; i < NCH; i++) begin dat[i] = '0; rs[i] = 0; end
    model_reset();
    @(negedge clk);
    for (int c = 0; c < 3; c++) tick();
    rst = 1'b0;
    for (int c = 0; c < NCYC; c++) begin
      if (!did_rst && c >= 1800 && ack != '0 && fifo_count >= 2) begin
        did_rst = 1;
        rst = 1'b1;
        #1;
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        model_reset();
        req = '0;
        for (int i = 0; i < NCH; i++) rs[i] = 0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
          dat[i] = DW'($urandom); req[i] = 1'b1; rs[i] = 1;
        end
      end else begin
        drive(c);
      end
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
